multicycle_control_unit: RTL
============================

MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 SHALL have parameter ALU_OP_W, default 3, ALU operation code width (>=3; codes zero-extended).
REQ-002 SHALL have parameter CNT_W, default 32, retired-instruction counter width.
REQ-003 SHALL have parameter EN_EXT, default 1, enables addi (0x08) and j (0x02); 0 makes both illegal.
REQ-004 SHALL have ports, in order:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset; one clock, asynchronous, active-low.
- opcode  in  6  instruction bits [31:26], held stable by datapath IR after FETCH.
- funct  in  6  instruction bits [5:0].
- zero  in  1  ALU zero flag (informative; branch gating is done in datapath via pc_write_cond).
- mem_ready  in  1  memory completes current read/write this cycle.
- pc_write / pc_write_cond / ir_write / iord  out  1 each  PC enable / branch enable / IR load / address select (1 = ALUOut).
- mem_read / mem_write  out  1 each  memory request strobes.
- reg_dst / reg_write / mem_to_reg  out  1 each  rd select / RF write / writeback from MDR.
- alu_src_a  out  1  0 = PC, 1 = A.
- alu_src_b  out  2  00 = B, 01 = const 4, 10 = ext imm, 11 = ext imm<<2.
- alu_op  out  ALU_OP_W  010 add, 110 sub, 000 and, 001 or, 111 slt.
- pc_src  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- imm_extend  out  1  0 = sign, 1 = zero extension.
- illegal_instr  out  1  one-cycle pulse on unsupported opcode/funct.
- state_o  out  4  current state encoding.
- instr_count  out  CNT_W  retired-instruction count.

Function
REQ-005 SHALL be a Moore FSM, states IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, IMMEXEC, IMMWB, JUMP; every output not listed for a state SHALL be 0.
REQ-006 IDLE: all outputs 0; next state FETCH unconditionally.
REQ-007 FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=add, pc_src=00; ir_write=pc_write=mem_ready; stay until mem_ready, then DECODE.
REQ-008 DECODE: alu_src_a=0, alu_src_b=11, alu_op=add; next: lw/sw->MEMADR, R-type->EXEC, beq->BRANCH, andi/ori/addi->IMMEXEC, j->JUMP; else illegal_instr=1 and FETCH.
REQ-009 R-type legal funct: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2a slt; other funct is illegal in DECODE.
REQ-010 MEMADR: alu_src_a=1, alu_src_b=10, alu_op=add, imm_extend=0; lw->MEMRD, sw->MEMWR.
REQ-011 MEMRD: iord=1, mem_read=1, wait mem_ready, then MEMWB; MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1, then FETCH.
REQ-012 MEMWR: iord=1, mem_write=1, wait mem_ready, then FETCH.
REQ-013 EXEC: alu_src_a=1, alu_src_b=00, alu_op from funct; ALUWB: reg_dst=1, reg_write=1, then FETCH.
REQ-014 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=sub, pc_write_cond=1, pc_src=01, then FETCH.
REQ-015 IMMEXEC: alu_src_a=1, alu_src_b=10; andi->and/imm_extend=1, ori->or/imm_extend=1, addi->add/imm_extend=0; IMMWB: reg_dst=0, reg_write=1, then FETCH.
REQ-016 JUMP: pc_src=10, pc_write=1, then FETCH.
REQ-017 Latency with mem_ready always 1: beq/j 3 cycles, R-type/imm/sw 4, lw 5; each wait cycle adds 1.
REQ-018 mem_ready SHALL be ignored outside FETCH, MEMRD, MEMWR.
REQ-019 instr_count SHALL increment by 1 in the final cycle of each legal instruction (MEMWB, MEMWR with mem_ready, ALUWB, BRANCH, IMMWB, JUMP); wraps modulo 2^CNT_W; illegal instructions not counted.

Reset
REQ-020 rst_n low SHALL asynchronously force state IDLE, instr_count 0 and all outputs 0, including mid-instruction and during memory wait.
REQ-021 First FETCH SHALL occur the second rising edge after rst_n deasserts.

Structure
REQ-022 Package mcu_pkg SHALL hold state enum, opcode/funct constants, ALU op codes and alu_src_b/pc_src encodings.
REQ-023 Sub-module alu_decoder (funct -> alu_op, legal flag) SHALL be instantiated once.

Verification
REQ-024 Reset then add (0x00/0x20), mem_ready=1 -> states IDLE,FETCH,DECODE,EXEC,ALUWB; alu_op=010; reg_write in ALUWB; instr_count=1.
REQ-025 lw (0x23), mem_ready low 2 cycles in MEMRD -> MEMRD held 3 cycles, mem_read=1,iord=1 throughout; mem_to_reg=1 in MEMWB.
REQ-026 ori (0x0D) -> IMMEXEC alu_op=001, imm_extend=1; addi (0x08) -> alu_op=010, imm_extend=0; EN_EXT=0 addi -> illegal_instr pulse, count unchanged.
REQ-027 opcode 0x00 funct 0x27 -> illegal_instr=1 one cycle in DECODE, next FETCH, no reg_write.
REQ-028 rst_n low in MEMWR -> outputs 0 same cycle; CNT_W=4 after 16 instructions -> instr_count=0.

Source files
------------

// File: rtl/mcu_pkg.sv
// rtl/mcu_pkg.sv - shared encodings for the multicycle control unit
package mcu_pkg;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_MEMADR  = 4'd3,
    S_MEMRD   = 4'd4,
    S_MEMWB   = 4'd5,
    S_MEMWR   = 4'd6,
    S_EXEC    = 4'd7,
    S_ALUWB   = 4'd8,
    S_BRANCH  = 4'd9,
    S_IMMEXEC = 4'd10,
    S_IMMWB   = 4'd11,
    S_JUMP    = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// rtl/alu_decoder.sv - R-type funct to ALU operation code with legality flag
module alu_decoder
  import mcu_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alu_code,
  output logic       legal
);

  always_comb begin
    alu_code = ALU_ADD;
    legal    = 1'b1;
    case (funct)
      FN_ADD:  alu_code = ALU_ADD;
      FN_SUB:  alu_code = ALU_SUB;
      FN_AND:  alu_code = ALU_AND;
      FN_OR:   alu_code = ALU_OR;
      FN_SLT:  alu_code = ALU_SLT;
      default: legal    = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - Moore FSM sequencing a multicycle MIPS-style datapath
module multicycle_control_unit
  import mcu_pkg::*;
#(
  parameter int ALU_OP_W = 3,
  parameter int CNT_W    = 32,
  parameter bit EN_EXT   = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [5:0]          opcode,
  input  logic [5:0]          funct,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic                ir_write,
  output logic                iord,
  output logic                mem_read,
  output logic                mem_write,
  output logic                reg_dst,
  output logic                reg_write,
  output logic                mem_to_reg,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic [1:0]          pc_src,
  output logic                imm_extend,
  output logic                illegal_instr,
  output logic [3:0]          state_o,
  output logic [CNT_W-1:0]    instr_count
);

  state_t     state;
  state_t     state_next;
  logic       rst_done;
  logic       retire;
  logic [2:0] alu_code;
  logic [2:0] fn_alu_code;
  logic       fn_legal;
  logic       unused_zero;

  // Branch gating happens in the datapath, so the zero flag is not consumed here.
  assign unused_zero = zero;
  assign state_o     = state;
  assign alu_op      = ALU_OP_W'(alu_code);

  alu_decoder u_alu_decoder (
    .funct    (funct),
    .alu_code (fn_alu_code),
    .legal    (fn_legal)
  );

  // rst_done holds IDLE for one full cycle after release so the first FETCH lands on the second edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      rst_done    <= 1'b0;
      instr_count <= '0;
    end else begin
      state    <= state_next;
      rst_done <= 1'b1;
      if (retire) begin
        instr_count <= instr_count + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_next    = state;
    retire        = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    ir_write      = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    mem_to_reg    = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_B;
    alu_code      = ALU_AND;
    pc_src        = PCSRC_ALU;
    imm_extend    = 1'b0;
    illegal_instr = 1'b0;

    case (state)
      S_IDLE: begin
        if (rst_done) state_next = S_FETCH;
      end
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        alu_code  = ALU_ADD;
        pc_src    = PCSRC_ALU;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) state_next = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b  = SRCB_IMM_SH2;
        alu_code   = ALU_ADD;
        state_next = S_FETCH;
        case (opcode)
          OP_LW, OP_SW:     state_next = S_MEMADR;
          OP_RTYPE:         if (fn_legal) state_next = S_EXEC;
          OP_BEQ:           state_next = S_BRANCH;
          OP_ANDI, OP_ORI:  state_next = S_IMMEXEC;
          OP_ADDI:          if (EN_EXT) state_next = S_IMMEXEC;
          OP_J:             if (EN_EXT) state_next = S_JUMP;
          default:          state_next = S_FETCH;
        endcase
        // Anything that falls back to FETCH from DECODE was not recognised.
        illegal_instr = (state_next == S_FETCH);
      end
      S_MEMADR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_IMM;
        alu_code   = ALU_ADD;
        state_next = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        iord     = 1'b1;
        mem_read = 1'b1;
        if (mem_ready) state_next = S_MEMWB;
      end
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_MEMWR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
        if (mem_ready) begin
          retire     = 1'b1;
          state_next = S_FETCH;
        end
      end
      S_EXEC: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_B;
        alu_code   = fn_alu_code;
        state_next = S_ALUWB;
      end
      S_ALUWB: begin
        reg_dst    = 1'b1;
        reg_write  = 1'b1;
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_src_b     = SRCB_B;
        alu_code      = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_src        = PCSRC_ALUOUT;
        retire        = 1'b1;
        state_next    = S_FETCH;
      end
      S_IMMEXEC: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_IMM;
        state_next = S_IMMWB;
        case (opcode)
          OP_ANDI: begin alu_code = ALU_AND; imm_extend = 1'b1; end
          OP_ORI:  begin alu_code = ALU_OR;  imm_extend = 1'b1; end
          default: begin alu_code = ALU_ADD; imm_extend = 1'b0; end
        endcase
      end
      S_IMMWB: begin
        reg_write  = 1'b1;
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_JUMP: begin
        pc_src     = PCSRC_JUMP;
        pc_write   = 1'b1;
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      default: state_next = S_IDLE;
    endcase
  end

endmodule
